// File: rtl/cam_pixel_capture.sv
// Sensor byte-stream capture: registers vsync/href/data, frames active bytes into pixel strobes with x/y.
// Latency: cam_data to pix_addr is 2 clk (input register, then output register).
// No backpressure: the sensor cannot be stalled; out-of-window bytes are dropped and flagged.
// Option: define CAPTURE_DECIMATE_EN for 2:1 decimation in both axes (WIDTH/HEIGHT must be even).
module cam_pixel_capture #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          continuous,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_data,
  output logic [7:0]    pix_addr,
  output logic          pix_valid,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          pix_eof,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          busy,
  output logic          frame_err
);

  // Counters carry one extra bit so they can hold WIDTH/HEIGHT even when 2**XW == WIDTH.
  localparam logic [XW:0] WIDTH_C  = (XW+1)'(WIDTH);
  localparam logic [YW:0] HEIGHT_C = (YW+1)'(HEIGHT);
`ifdef CAPTURE_DECIMATE_EN
  localparam logic [XW:0] X_LAST  = (XW+1)'(WIDTH - 2);
  localparam logic [YW:0] Y_LAST  = (YW+1)'(HEIGHT - 2);
`else
  localparam logic [XW:0] X_LAST  = (XW+1)'(WIDTH - 1);
  localparam logic [YW:0] Y_LAST  = (YW+1)'(HEIGHT - 1);
`endif

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  state_t        state, state_nxt;
  logic          vs_r, hr_r, vs_p, hr_p;
  logic [7:0]    d_r;
  logic [XW:0]   x, x_nxt;
  logic [YW:0]   y, y_nxt;
  logic          err_nxt, busy_nxt;
  logic          valid_nxt, sof_nxt, eol_nxt, eof_nxt;
  logic [7:0]    addr_nxt;
  logic [XW-1:0] px_nxt;
  logic [YW-1:0] py_nxt;
  logic          vs_fall, vs_rise, hr_fall, in_window, emit;

  assign vs_fall   = vs_p & ~vs_r;
  assign vs_rise   = ~vs_p & vs_r;
  assign hr_fall   = hr_p & ~hr_r;
  assign in_window = (x < WIDTH_C) && (y < HEIGHT_C);
`ifdef CAPTURE_DECIMATE_EN
  assign emit      = ~x[0] & ~y[0];
`else
  assign emit      = 1'b1;
`endif

  // Input registers plus a delayed copy of the control lines for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_r <= 1'b0;
      hr_r <= 1'b0;
      d_r  <= 8'h00;
      vs_p <= 1'b0;
      hr_p <= 1'b0;
    end else begin
      vs_r <= cam_vsync;
      hr_r <= cam_href;
      d_r  <= cam_data;
      vs_p <= vs_r;
      hr_p <= hr_r;
    end
  end

  // Next-state, counter and output decode; strobes default low, data outputs hold.
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    err_nxt   = frame_err;
    valid_nxt = 1'b0;
    sof_nxt   = 1'b0;
    eol_nxt   = 1'b0;
    eof_nxt   = 1'b0;
    addr_nxt  = pix_addr;
    px_nxt    = pix_x;
    py_nxt    = pix_y;
    case (state)
      IDLE: begin
        // A frame start seen in the same cycle is ignored: capture waits for the next one.
        if (arm) begin
          state_nxt = ARMED;
          err_nxt   = 1'b0;
        end
      end
      ARMED: begin
        if (vs_fall) begin
          state_nxt = ACTIVE;
          x_nxt     = '0;
          y_nxt     = '0;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          // Frame end wins over any byte in flight; the current line is abandoned.
          if ((y != HEIGHT_C) || hr_r) err_nxt = 1'b1;
          x_nxt     = '0;
          state_nxt = continuous ? ARMED : IDLE;
        end else if (hr_r) begin
          if (in_window) begin
            x_nxt = x + 1'b1;
            if (emit) begin
              valid_nxt = 1'b1;
              addr_nxt  = d_r;
`ifdef CAPTURE_DECIMATE_EN
              px_nxt    = x[XW:1];
              py_nxt    = y[YW:1];
`else
              px_nxt    = x[XW-1:0];
              py_nxt    = y[YW-1:0];
`endif
              sof_nxt   = (x == '0) && (y == '0);
              eol_nxt   = (x == X_LAST);
              eof_nxt   = (x == X_LAST) && (y == Y_LAST);
            end
          end else begin
            err_nxt = 1'b1;
          end
        end else if (hr_fall) begin
          if (x != WIDTH_C) err_nxt = 1'b1;
          x_nxt = '0;
          if (y != HEIGHT_C) y_nxt = y + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
      pix_addr  <= 8'h00;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      state     <= state_nxt;
      x         <= x_nxt;
      y         <= y_nxt;
      frame_err <= err_nxt;
      busy      <= busy_nxt;
      pix_valid <= valid_nxt;
      pix_sof   <= sof_nxt;
      pix_eol   <= eol_nxt;
      pix_eof   <= eof_nxt;
      pix_addr  <= addr_nxt;
      pix_x     <= px_nxt;
      pix_y     <= py_nxt;
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture with a 4x2 frame geometry.
// Strobes are recorded by a monitor; checks are immediate assertions in one stimulus sequence.
// Define CAPTURE_DECIMATE_EN to check the decimated build.
module tb_cam_pixel_capture;
  logic       clk = 1'b0;
  logic       reset, arm, continuous, cam_vsync, cam_href;
  logic [7:0] cam_data;
  logic [7:0] pix_addr;
  logic       pix_valid, pix_sof, pix_eol, pix_eof, busy, frame_err;
  logic [1:0] pix_x;
  logic [0:0] pix_y;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q_addr[$];
  logic [2:0] q_flag[$];
  logic [1:0] q_x[$];
  logic [0:0] q_y[$];

`ifdef CAPTURE_DECIMATE_EN
  localparam int N1 = 2;
  localparam int NF = 2;
  logic [7:0] e_addr [N1] = '{8'h10, 8'h12};
  logic [2:0] e_flag [N1] = '{3'b100, 3'b011};
  logic [1:0] e_x    [N1] = '{2'd0, 2'd1};
  logic [0:0] e_y    [N1] = '{1'b0, 1'b0};
`else
  localparam int N1 = 8;
  localparam int NF = 8;
  logic [7:0] e_addr [N1] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
  logic [2:0] e_flag [N1] = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b011};
  logic [1:0] e_x    [N1] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [0:0] e_y    [N1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

  cam_pixel_capture #(.WIDTH(4), .HEIGHT(2), .XW(2), .YW(1)) dut (
    .clk(clk), .reset(reset), .arm(arm), .continuous(continuous),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .pix_addr(pix_addr), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .pix_eof(pix_eof), .pix_x(pix_x), .pix_y(pix_y),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Record every strobe just after the clock edge.
  always @(posedge clk) begin
    #1;
    if (pix_valid === 1'b1) begin
      q_addr.push_back(pix_addr);
      q_flag.push_back({pix_sof, pix_eol, pix_eof});
      q_x.push_back(pix_x);
      q_y.push_back(pix_y);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic send_line(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      cam_href = 1'b1;
      cam_data = base + 8'(i);
      step();
    end
    cam_href = 1'b0;
    cam_data = 8'h00;
    idle(3);
  endtask

  task automatic frame_start();
    cam_vsync = 1'b0;
    idle(3);
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    idle(4);
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_flag.delete();
    q_x.delete();
    q_y.delete();
  endtask

  function automatic int count_eof();
    int n = 0;
    foreach (q_flag[i]) if (q_flag[i][0]) n++;
    return n;
  endfunction

  initial begin
    reset = 1'b1; arm = 1'b0; continuous = 1'b0;
    cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
    idle(3);
    chk("reset_outputs", {pix_addr, pix_valid, pix_sof, pix_eol, pix_eof, pix_x, pix_y, busy, frame_err}, 32'h0);
    reset = 1'b0;
    idle(2);

    // Clean 4x2 frame, data 0x10..0x17.
    pulse_arm();
    chk("t1_busy_armed", busy, 1);
    frame_start();
    send_line(4, 8'h10);
    send_line(4, 8'h14);
    frame_end();
    chk("t1_count", q_addr.size(), N1);
    if (q_addr.size() == N1) begin
      for (int i = 0; i < N1; i++) begin
        chk($sformatf("t1_addr%0d", i), q_addr[i], e_addr[i]);
        chk($sformatf("t1_flag%0d", i), q_flag[i], e_flag[i]);
        chk($sformatf("t1_xy%0d", i), {q_y[i], q_x[i]}, {e_y[i], e_x[i]});
      end
    end
    chk("t1_err", frame_err, 0);
    chk("t1_busy_end", busy, 0);
    clear_q();

    // Latency: byte presented after one edge appears two edges later.
    pulse_arm();
    frame_start();
    cam_href = 1'b1; cam_data = 8'hA5;
    step();
    chk("t2_not_yet", pix_valid, 0);
    cam_data = 8'hA6;
    step();
    chk("t2_valid", pix_valid, 1);
    chk("t2_addr", pix_addr, 8'hA5);
    cam_data = 8'hA7; step();
    cam_data = 8'hA8; step();
    cam_href = 1'b0; idle(3);
    send_line(4, 8'hB0);
    frame_end();
    chk("t2_err", frame_err, 0);
    clear_q();

    // Overlong first line: fifth byte dropped, error flagged, next arm clears it.
    pulse_arm();
    frame_start();
    send_line(5, 8'h20);
    send_line(4, 8'h25);
    frame_end();
    chk("t3_count", q_addr.size(), NF);
`ifndef CAPTURE_DECIMATE_EN
    if (q_addr.size() == NF) begin
      chk("t3_last_l0", q_addr[3], 8'h23);
      chk("t3_first_l1", q_addr[4], 8'h25);
    end
`endif
    chk("t3_err_set", frame_err, 1);
    chk("t3_busy", busy, 0);
    pulse_arm();
    chk("t3_err_clr", frame_err, 0);
    chk("t3_rearmed", busy, 1);
    frame_start();
    send_line(4, 8'h40);
    send_line(4, 8'h44);
    frame_end();
    chk("t3_clean_err", frame_err, 0);
    clear_q();

    // Arm in the same cycle the frame start is seen: that frame must be skipped.
    cam_vsync = 1'b0;
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    idle(2);
    send_line(4, 8'h50);
    send_line(4, 8'h54);
    frame_end();
    chk("t_arm_sof_skip", q_addr.size(), 0);
    chk("t_arm_sof_busy", busy, 1);

    // Continuous mode: three back-to-back frames.
    continuous = 1'b1;
    pulse_arm();
    for (int f = 0; f < 3; f++) begin
      frame_start();
      send_line(4, 8'h60);
      send_line(4, 8'h64);
      if (f == 2) continuous = 1'b0;
      frame_end();
      if (f < 2) chk($sformatf("t4_busy_f%0d", f), busy, 1);
    end
    chk("t4_count", q_addr.size(), 3 * NF);
    chk("t4_eofs", count_eof(), 3);
    chk("t4_busy_end", busy, 0);
    chk("t4_err", frame_err, 0);
    clear_q();

    // Reset in the middle of a line.
    pulse_arm();
    frame_start();
    cam_href = 1'b1; cam_data = 8'h30; step();
    cam_data = 8'h31; step();
    reset = 1'b1;
    step();
    chk("t5_reset_outputs", {pix_addr, pix_valid, pix_sof, pix_eol, pix_eof, pix_x, pix_y, busy, frame_err}, 32'h0);
    reset = 1'b0;
    cam_href = 1'b0; cam_data = 8'h00;
    idle(3);
    clear_q();
    send_line(4, 8'h34);
    frame_end();
    frame_start();
    send_line(4, 8'h70);
    send_line(4, 8'h74);
    frame_end();
    chk("t5_no_strobes", q_addr.size(), 0);
    chk("t5_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
